sequenciador_senhas: RTL

SEQUENCIADOR_SENHAS -- requirements
Module: sequenciador_senhas

---
 rtl/sequenciador_senhas_pkg.sv | 28 ++
 rtl/proximo_slot.sv | 28 ++
 rtl/sequenciador_senhas.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_senhas_pkg.sv
// Shared types for the password sequencer: typed password, FSM states, slot width
// and the saturating failure-count helper.
package sequenciador_senhas_pkg;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } senhaPac_t;

  localparam int SLOT_W = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT     = 3'd2,
    NEXT     = 3'd3,
    RES_OK   = 3'd4,
    RES_FAIL = 3'd5,
    LOCKED   = 3'd6
  } estado_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : (v + 4'd1);
  endfunction

endpackage

// File: rtl/proximo_slot.sv
// Combinational search for the lowest enabled slot strictly above the current one.
module proximo_slot
  import sequenciador_senhas_pkg::*;
#(
  parameter int N_SLOT = 5
) (
  input  logic [SLOT_W-1:0] cur_i,
  input  logic [N_SLOT-1:0] en_i,
  output logic              found_o,
  output logic [SLOT_W-1:0] next_o
);

  // Scan from the top down so the lowest qualifying slot is the one left standing.
  always_comb begin
    found_o = 1'b0;
    next_o  = '0;
    for (int i = N_SLOT - 1; i >= 0; i--) begin
      if (en_i[i] && (SLOT_W'(i) > cur_i)) begin
        found_o = 1'b1;
        next_o  = SLOT_W'(i);
      end else begin
        found_o = found_o;
        next_o  = next_o;
      end
    end
  end

endmodule

// File: rtl/sequenciador_senhas.sv
// Password sequencer: walks master then enabled user slots through an external
// verifier, reports the first match, and locks out after repeated failures.
module sequenciador_senhas
  import sequenciador_senhas_pkg::*;
#(
  parameter int N_USER      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYC    = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  senhaPac_t         senha_teste,
  input  senhaPac_t         senha_master,
  input  senhaPac_t         senha_user [N_USER],
  input  logic [N_USER-1:0] user_en,
  output logic              vs_valid,
  output senhaPac_t         vs_senha_teste,
  output senhaPac_t         vs_senha_real,
  input  logic              vs_done,
  input  logic              vs_senha_ok,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [SLOT_W-1:0] match_id,
  output logic              bloqueado,
  output logic [3:0]        fail_cnt
);

  localparam logic [7:0]  TMO_LAST  = 8'(TIMEOUT_CYC - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYC - 1);
  localparam logic [3:0]  FAIL_LIM  = 4'(MAX_FAIL);

  estado_t           state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  senhaPac_t         att_q, att_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [15:0]       lock_q, lock_d;
  logic [3:0]        fail_q, fail_d;

  logic              vs_valid_q, busy_q, done_q, match_q, bloq_q;
  logic [SLOT_W-1:0] match_id_q;
  senhaPac_t         real_q, real_s;

  logic [N_USER:0]   en_s;
  logic              prox_found_s;
  logic [SLOT_W-1:0] prox_slot_s;
  logic [3:0]        fail_inc_s;

  // Slot 0 (master) can never be disabled.
  assign en_s       = {user_en, 1'b1};
  assign fail_inc_s = sat_inc4(fail_q);

  proximo_slot #(.N_SLOT(N_USER + 1)) u_proximo_slot (
    .cur_i  (slot_q),
    .en_i   (en_s),
    .found_o(prox_found_s),
    .next_o (prox_slot_s)
  );

  // Next-state logic for the attempt sequencer.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    att_d   = att_q;
    tmo_d   = tmo_q;
    lock_d  = lock_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          att_d   = senha_teste;
          slot_d  = '0;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        tmo_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (vs_done) begin
          state_d = vs_senha_ok ? RES_OK : NEXT;
        end else if (tmo_q == TMO_LAST) begin
          state_d = NEXT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      NEXT: begin
        if (prox_found_s) begin
          slot_d  = prox_slot_s;
          state_d = ISSUE;
        end else begin
          state_d = RES_FAIL;
        end
      end
      RES_OK: begin
        fail_d  = 4'd0;
        state_d = IDLE;
      end
      RES_FAIL: begin
        fail_d = fail_inc_s;
        if (fail_inc_s == FAIL_LIM) begin
          lock_d  = 16'd0;
          state_d = LOCKED;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (lock_q == LOCK_LAST) begin
          lock_d  = 16'd0;
          fail_d  = 4'd0;
          state_d = IDLE;
        end else begin
          lock_d = lock_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Password of the slot about to be issued.
  always_comb begin
    real_s = senha_master;
    for (int k = 0; k < N_USER; k++) begin
      if (slot_d == SLOT_W'(k + 1)) begin
        real_s = senha_user[k];
      end else begin
        real_s = real_s;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      att_q   <= '0;
      tmo_q   <= 8'd0;
      lock_q  <= 16'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      att_q   <= att_d;
      tmo_q   <= tmo_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
    end
  end

  // Outputs registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      match_id_q <= '0;
      bloq_q     <= 1'b0;
      real_q     <= '0;
    end else begin
      vs_valid_q <= (state_d == ISSUE);
      busy_q     <= !((state_d == IDLE) || (state_d == LOCKED));
      done_q     <= (state_d == RES_OK) || (state_d == RES_FAIL);
      match_q    <= (state_d == RES_OK);
      match_id_q <= (state_d == RES_OK) ? slot_d : '0;
      bloq_q     <= (state_d == LOCKED);
      // Reload only on ISSUE so the verifier sees a frozen password for the whole wait.
      real_q     <= (state_d == ISSUE) ? real_s : real_q;
    end
  end

  assign vs_valid       = vs_valid_q;
  assign vs_senha_teste = att_q;
  assign vs_senha_real  = real_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign match          = match_q;
  assign match_id       = match_id_q;
  assign bloqueado      = bloq_q;
  assign fail_cnt       = fail_q;

endmodule
